// File: rtl/any1_pkg.sv
// Shared types and constants for the ANY-1 TLB miss walker: FSM states,
// fault codes, PTE bit positions and TLB entry field layout.
package any1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BUS,
        CHECK,
        WRITE,
        DONE,
        FAULT,
        INVAL
    } state_e;

    localparam logic [1:0] FAULT_NONE = 2'd0;
    localparam logic [1:0] FAULT_PTE  = 2'd1;
    localparam logic [1:0] FAULT_BUS  = 2'd2;

    // PTE layout (source of the fill)
    localparam int PTE_V_BIT   = 52;
    localparam int PTE_G_BIT   = 55;
    localparam int PTE_ACR_LSB = 48;

    // TLB entry layout (destination of the fill)
    localparam int ENT_ASID_LSB = 56;
    localparam int ENT_G_BIT    = 55;
    localparam int ENT_ACR_LSB  = 48;
    localparam int ENT_TAG_LSB  = 32;

    // Virtual address split: index = vaddr[23:14], tag = vaddr[AWID-1:24]
    localparam int VPN_LSB = 14;
    localparam int TAG_LSB = 24;
    localparam int IDX_W   = 10;

endpackage

// File: rtl/any1_tlb_entry_fmt.sv
// Combinational TLB entry builder: merges PTE, virtual tag and ASID into the
// 64-bit word written into the ANY-1 TLB. Also usable for software-fill checks.
module any1_tlb_entry_fmt
    import any1_pkg::*;
#(
    parameter int AWID = 32
) (
    input  logic [63:0]     pte_i,
    input  logic [AWID-1:0] vaddr_i,
    input  logic [7:0]      asid_i,
    output logic [63:0]     entry_o
);

    localparam int PPN_W = AWID - 14;
    localparam int TAG_W = AWID - TAG_LSB;

    always_comb begin
        // NOTE: assigning a full default first means no path leaves a bit
        // unassigned, so this block can never infer a latch.
        entry_o                         = '0;
        entry_o[ENT_ASID_LSB +: 8]      = asid_i;
        entry_o[ENT_G_BIT]              = pte_i[PTE_G_BIT];
        entry_o[ENT_ACR_LSB +: 4]       = pte_i[PTE_ACR_LSB +: 4];
        entry_o[ENT_TAG_LSB +: TAG_W]   = vaddr_i[AWID-1:TAG_LSB];
        entry_o[PPN_W-1:0]              = pte_i[PPN_W-1:0];
    end

    // PTE/vaddr bits that have no place in the entry
    logic unused_bits;
    assign unused_bits = ^{pte_i[63:56], pte_i[54:52], pte_i[47:PPN_W],
                           vaddr_i[TAG_LSB-1:0]};

endmodule

// File: rtl/any1_tlb_walker.sv
// ANY-1 hardware TLB-miss walker: one PTE fetch over the bus, entry build,
// round-robin way write. Optional invalidate-all sweep: ANY1_TLBW_INVAL_EN.
module any1_tlb_walker
    import any1_pkg::*;
#(
    parameter int AWID    = 32,
    parameter int BUS_TMO = 255    // 1..255, fits the 8-bit timeout counter
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            miss_i,
    input  logic [AWID-1:0] miss_adr_i,
    input  logic [7:0]      asid_i,
    input  logic [AWID-1:0] ptbr_i,
    input  logic            inv_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            fault_o,
    output logic [1:0]      fault_code_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic [AWID-1:0] adr_o,
    input  logic            ack_i,
    input  logic [63:0]     dat_i,
    output logic            tlben_o,
    output logic            wrtlb_o,
    output logic [11:0]     tlbadr_o,
    output logic [63:0]     tlbdat_o
);

    localparam int VPN_W = AWID - VPN_LSB;

    state_e           state_q, state_d;
    logic [VPN_W-1:0] vpn_q, vpn_d;
    logic [7:0]       asid_q, asid_d;
    logic [63:0]      pte_q, pte_d;
    logic [1:0]       way_q, way_d;
    logic [7:0]       tmo_q, tmo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic [1:0]       fault_code_q, fault_code_d;
    logic             cyc_q, cyc_d;
    logic [AWID-1:0]  adr_q, adr_d;
    logic             wr_q, wr_d;
    logic [11:0]      tlbadr_q, tlbadr_d;
    logic [63:0]      tlbdat_q, tlbdat_d;
    logic [63:0]      entry;

    any1_tlb_entry_fmt #(.AWID(AWID)) u_fmt (
        .pte_i   (pte_q),
        .vaddr_i ({vpn_q, {VPN_LSB{1'b0}}}),
        .asid_i  (asid_q),
        .entry_o (entry)
    );

    always_comb begin
        state_d      = state_q;
        vpn_d        = vpn_q;
        asid_d       = asid_q;
        pte_d        = pte_q;
        way_d        = way_q;
        tmo_d        = tmo_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        fault_d      = 1'b0;
        fault_code_d = fault_code_q;
        cyc_d        = cyc_q;
        adr_d        = adr_q;
        wr_d         = 1'b0;
        tlbadr_d     = tlbadr_q;
        tlbdat_d     = tlbdat_q;

        case (state_q)
            IDLE: begin
                if (miss_i) begin
                    vpn_d        = miss_adr_i[AWID-1:VPN_LSB];
                    asid_d       = asid_i;
                    adr_d        = ptbr_i + AWID'({miss_adr_i[AWID-1:VPN_LSB], 3'b000});
                    cyc_d        = 1'b1;
                    busy_d       = 1'b1;
                    tmo_d        = '0;
                    fault_code_d = FAULT_NONE;
                    state_d      = BUS;
                end
`ifdef ANY1_TLBW_INVAL_EN
                else if (inv_i) begin
                    tlbadr_d = '0;
                    tlbdat_d = '0;
                    wr_d     = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = INVAL;
                end
`endif
            end
            BUS: begin
                tmo_d = tmo_q + 8'd1;
                // ack wins over a timeout expiring on the same edge
                if (ack_i) begin
                    pte_d   = dat_i;
                    cyc_d   = 1'b0;
                    state_d = CHECK;
                end else if (tmo_d == 8'(BUS_TMO)) begin
                    cyc_d        = 1'b0;
                    busy_d       = 1'b0;
                    fault_d      = 1'b1;
                    fault_code_d = FAULT_BUS;
                    state_d      = FAULT;
                end
            end
            CHECK: begin
                if (!pte_q[PTE_V_BIT]) begin
                    busy_d       = 1'b0;
                    fault_d      = 1'b1;
                    fault_code_d = FAULT_PTE;
                    state_d      = FAULT;
                end else begin
                    tlbadr_d = {way_q, vpn_q[IDX_W-1:0]};
                    tlbdat_d = entry;
                    wr_d     = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                way_d   = way_q + 2'd1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE:  state_d = IDLE;
            FAULT: state_d = IDLE;
`ifdef ANY1_TLBW_INVAL_EN
            INVAL: begin
                if (tlbadr_q == 12'hFFF) begin
                    way_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    tlbadr_d = tlbadr_q + 12'd1;
                    wr_d     = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous and clears every register, data holders
        // included, so all outputs read zero right after the reset edge.
        if (!rst_ni) begin
            state_q      <= IDLE;
            vpn_q        <= '0;
            asid_q       <= '0;
            pte_q        <= '0;
            way_q        <= '0;
            tmo_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= FAULT_NONE;
            cyc_q        <= 1'b0;
            adr_q        <= '0;
            wr_q         <= 1'b0;
            tlbadr_q     <= '0;
            tlbdat_q     <= '0;
        end else begin
            // NOTE: non-blocking updates let every flop sample the pre-edge
            // value of every other flop, independent of statement order.
            state_q      <= state_d;
            vpn_q        <= vpn_d;
            asid_q       <= asid_d;
            pte_q        <= pte_d;
            way_q        <= way_d;
            tmo_q        <= tmo_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            cyc_q        <= cyc_d;
            adr_q        <= adr_d;
            wr_q         <= wr_d;
            tlbadr_q     <= tlbadr_d;
            tlbdat_q     <= tlbdat_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign fault_o      = fault_q;
    assign fault_code_o = fault_code_q;
    assign cyc_o        = cyc_q;
    assign stb_o        = cyc_q;
    assign adr_o        = adr_q;
    assign tlben_o      = wr_q;
    assign wrtlb_o      = wr_q;
    assign tlbadr_o     = tlbadr_q;
    assign tlbdat_o     = tlbdat_q;

    logic unused_in;
`ifdef ANY1_TLBW_INVAL_EN
    assign unused_in = ^miss_adr_i[VPN_LSB-1:0];
`else
    assign unused_in = ^{miss_adr_i[VPN_LSB-1:0], inv_i};
`endif

endmodule

// File: tb/tb_any1_tlb_walker.sv
// Self-checking bench for any1_tlb_walker: directed and randomized walks
// against a behavioural model of address, entry format and way rotation.
`timescale 1ns/1ps
module tb_any1_tlb_walker;

    localparam int AWID = 32;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            miss_i = 1'b0;
    logic [AWID-1:0] miss_adr_i = '0;
    logic [7:0]      asid_i = '0;
    logic [AWID-1:0] ptbr_i = '0;
    logic            inv_i = 1'b0;
    logic            ack_i = 1'b0;
    logic [63:0]     dat_i = '0;
    logic            busy_o, done_o, fault_o, cyc_o, stb_o, tlben_o, wrtlb_o;
    logic [1:0]      fault_code_o;
    logic [AWID-1:0] adr_o;
    logic [11:0]     tlbadr_o;
    logic [63:0]     tlbdat_o;

    always #5 clk_i = ~clk_i;

    any1_tlb_walker #(.AWID(AWID), .BUS_TMO(255)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .miss_i(miss_i), .miss_adr_i(miss_adr_i),
        .asid_i(asid_i), .ptbr_i(ptbr_i), .inv_i(inv_i), .busy_o(busy_o),
        .done_o(done_o), .fault_o(fault_o), .fault_code_o(fault_code_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o), .ack_i(ack_i), .dat_i(dat_i),
        .tlben_o(tlben_o), .wrtlb_o(wrtlb_o), .tlbadr_o(tlbadr_o), .tlbdat_o(tlbdat_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    int way_model = 0;

    // Observations of the most recent walk
    int          obs_bus, obs_writes, obs_wr_c, obs_done_c, obs_fault_c, obs_busy_err, obs_pair_err;
    bit          obs_end;
    logic [31:0] obs_adr;
    logic [11:0] obs_tlbadr;
    logic [63:0] obs_tlbdat;
    logic [1:0]  obs_code;

    function automatic logic [31:0] model_adr(input logic [31:0] ptbr, input logic [31:0] va);
        return ptbr + ((va >> 14) << 3);
    endfunction

    function automatic logic [63:0] model_entry(input logic [31:0] va, input logic [7:0] asid,
                                                input logic [63:0] pte);
        logic [63:0] e;
        e = 64'(asid) << 56;
        e = e | (((pte >> 55) & 64'h1) << 55);
        e = e | (((pte >> 48) & 64'hF) << 48);
        e = e | (64'(va >> 24) << 32);
        e = e | (pte & ((64'd1 << (AWID - 14)) - 64'd1));
        return e;
    endfunction

    function automatic logic [11:0] model_tlbadr(input int way, input logic [31:0] va);
        return 12'((way << 10) | ((va >> 14) & 32'h3FF));
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0; miss_i = 1'b0; inv_i = 1'b0; ack_i = 1'b0;
        tick(); tick();
        rst_ni = 1'b1;
        way_model = 0;
    endtask

    // One miss; ack_at = BUS cycle (1-based) in which ack_i is driven, 0 = never
    task automatic run_walk(input logic [31:0] va, input logic [7:0] asid,
                            input logic [31:0] ptbr, input logic [63:0] pte, input int ack_at);
        miss_adr_i = va; asid_i = asid; ptbr_i = ptbr; dat_i = '0; miss_i = 1'b1;
        obs_bus = 0; obs_writes = 0; obs_wr_c = -1; obs_done_c = -1; obs_fault_c = -1;
        obs_busy_err = 0; obs_pair_err = 0; obs_end = 0;
        obs_adr = '0; obs_tlbadr = '0; obs_tlbdat = '0; obs_code = '0;
        tick();
        miss_i = 1'b0;
        for (int c = 0; c < 600 && !obs_end; c++) begin
            ack_i = 1'b0;
            if (stb_o !== cyc_o || tlben_o !== wrtlb_o) obs_pair_err++;
            if (cyc_o) begin
                obs_bus++;
                if (obs_bus == 1) obs_adr = adr_o;
                if (obs_bus == ack_at) begin ack_i = 1'b1; dat_i = pte; end
            end
            if (wrtlb_o) begin
                obs_writes++; obs_wr_c = c; obs_tlbadr = tlbadr_o; obs_tlbdat = tlbdat_o;
            end
            if (done_o) begin obs_done_c = c; obs_end = 1; end
            if (fault_o) begin obs_fault_c = c; obs_code = fault_code_o; obs_end = 1; end
            if (busy_o !== !obs_end) obs_busy_err++;
            tick();
        end
        ack_i = 1'b0;
        n_cmp++;
        if (!obs_end) begin n_err++; $display("FAIL walk_end: no done/fault within 600 cycles"); end
        n_cmp++;
        if (obs_busy_err != 0 || obs_pair_err != 0) begin
            n_err++;
            $display("FAIL walk_handshake: busy errors %0d, stb/tlben pair errors %0d, want 0/0",
                     obs_busy_err, obs_pair_err);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; miss_i = 1'b1; inv_i = 1'b1;
        tick();
        n_cmp++;
        if ({busy_o, done_o, fault_o, cyc_o, stb_o, tlben_o, wrtlb_o} !== 7'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 0000000",
                              {busy_o, done_o, fault_o, cyc_o, stb_o, tlben_o, wrtlb_o});
        end
        n_cmp++;
        if (fault_code_o !== 2'd0 || adr_o !== '0) begin
            n_err++; $display("FAIL reset_code_adr: got code %0d adr %h want 0/0", fault_code_o, adr_o);
        end
        n_cmp++;
        if (tlbadr_o !== 12'h0 || tlbdat_o !== 64'h0) begin
            n_err++; $display("FAIL reset_tlb: got %h/%h want 0/0", tlbadr_o, tlbdat_o);
        end
        miss_i = 1'b0; inv_i = 1'b0;
        apply_reset();
    endtask

    task automatic test_fill();
        logic [31:0] va = 32'h1234_5678;
        apply_reset();
        run_walk(va, 8'h05, 32'h0010_0000, 64'h001F_0000_0000_0ABC, 2);
        n_cmp++;
        if (obs_adr !== 32'h0012_4688) begin
            n_err++; $display("FAIL fill_adr: got %h want 00124688", obs_adr);
        end
        n_cmp++;
        if (obs_writes != 1 || obs_tlbadr !== 12'h0D1) begin
            n_err++; $display("FAIL fill_tlbadr: got %0d writes adr %h want 1 / 0d1", obs_writes, obs_tlbadr);
        end
        n_cmp++;
        if (obs_tlbdat !== 64'h050F_0012_0000_0ABC) begin
            n_err++; $display("FAIL fill_tlbdat: got %h want 050f001200000abc", obs_tlbdat);
        end
        n_cmp++;
        if (obs_wr_c != 3 || obs_done_c != 4 || obs_fault_c != -1) begin
            n_err++; $display("FAIL fill_timing: got wr %0d done %0d fault %0d want 3/4/-1",
                              obs_wr_c, obs_done_c, obs_fault_c);
        end
        n_cmp++;
        if (fault_code_o !== 2'd0 || done_o !== 1'b0) begin
            n_err++; $display("FAIL fill_after: got code %0d done %b want 0/0", fault_code_o, done_o);
        end
        way_model = (way_model + 1) % 4;
    endtask

    task automatic test_round_robin();
        logic [31:0] va = 32'h8765_4321;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            run_walk(va, 8'hA5, 32'h0000_8000, 64'h0090_0000_0001_2345, 1);
            n_cmp++;
            if (obs_writes != 1 || obs_tlbadr !== model_tlbadr(way_model, va)) begin
                n_err++; $display("FAIL rr_way%0d: got %0d writes adr %h want 1 / %h", i,
                                  obs_writes, obs_tlbadr, model_tlbadr(way_model, va));
            end
            n_cmp++;
            if (obs_wr_c != 2 || obs_done_c != 3) begin
                n_err++; $display("FAIL rr_latency%0d: got wr %0d done %0d want 2/3", i, obs_wr_c, obs_done_c);
            end
            way_model = (way_model + 1) % 4;
        end
    endtask

    task automatic test_invalid_pte();
        logic [31:0] va = 32'h1234_5678;
        run_walk(va, 8'h05, 32'h0010_0000, 64'h000F_0000_0000_0ABC, 3);
        n_cmp++;
        if (obs_fault_c < 0 || obs_code !== 2'd1 || obs_writes != 0) begin
            n_err++; $display("FAIL invpte_fault: got fault@%0d code %0d writes %0d want seen/1/0",
                              obs_fault_c, obs_code, obs_writes);
        end
        n_cmp++;
        if (fault_code_o !== 2'd1 || fault_o !== 1'b0) begin
            n_err++; $display("FAIL invpte_hold: got code %0d pulse %b want 1/0", fault_code_o, fault_o);
        end
        run_walk(va, 8'h05, 32'h0010_0000, 64'h001F_0000_0000_0ABC, 1);
        n_cmp++;
        if (obs_tlbadr !== model_tlbadr(way_model, va)) begin
            n_err++; $display("FAIL invpte_way: got %h want %h", obs_tlbadr, model_tlbadr(way_model, va));
        end
        way_model = (way_model + 1) % 4;
    endtask

    task automatic test_timeout();
        logic [31:0] va = 32'hFFFF_C000;
        run_walk(va, 8'h11, 32'hFFFF_0000, 64'h0010_0000_0000_0001, 0);
        n_cmp++;
        if (obs_bus != 255 || obs_code !== 2'd2 || obs_writes != 0) begin
            n_err++; $display("FAIL tmo_fault: got %0d bus cycles code %0d writes %0d want 255/2/0",
                              obs_bus, obs_code, obs_writes);
        end
        n_cmp++;
        if (obs_adr !== model_adr(32'hFFFF_0000, va)) begin
            n_err++; $display("FAIL tmo_adr_wrap: got %h want %h", obs_adr, model_adr(32'hFFFF_0000, va));
        end
        tick(); tick(); tick();
        n_cmp++;
        if (fault_code_o !== 2'd2 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL tmo_hold: got code %0d busy %b want 2/0", fault_code_o, busy_o);
        end
        run_walk(va, 8'h11, 32'hFFFF_0000, 64'h0010_0000_0000_0001, 255);
        n_cmp++;
        if (obs_bus != 255 || obs_writes != 1 || obs_fault_c != -1 ||
            obs_tlbadr !== model_tlbadr(way_model, va)) begin
            n_err++; $display("FAIL tmo_late_ack: got %0d bus %0d writes fault@%0d adr %h want 255/1/-1/%h",
                              obs_bus, obs_writes, obs_fault_c, obs_tlbadr, model_tlbadr(way_model, va));
        end
        n_cmp++;
        if (fault_code_o !== 2'd0) begin
            n_err++; $display("FAIL tmo_code_clear: got %0d want 0", fault_code_o);
        end
        way_model = (way_model + 1) % 4;
    endtask

    task automatic test_reset_midwalk();
        int wr_seen = 0;
        logic [31:0] va = 32'h0040_0000;
        apply_reset();
        run_walk(va, 8'h22, 32'h0, 64'h0010_0000_0000_0777, 1);
        miss_adr_i = va; miss_i = 1'b1;
        tick();
        miss_i = 1'b0;
        tick(); tick(); tick();
        rst_ni = 1'b0;
        tick();
        n_cmp++;
        if (cyc_o !== 1'b0 || busy_o !== 1'b0 || wrtlb_o !== 1'b0) begin
            n_err++; $display("FAIL rstmid_drop: got cyc %b busy %b wr %b want 0/0/0", cyc_o, busy_o, wrtlb_o);
        end
        rst_ni = 1'b1; way_model = 0;
        ack_i = 1'b1; dat_i = 64'h0010_0000_0000_0777;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (wrtlb_o || cyc_o) wr_seen++;
        end
        ack_i = 1'b0;
        n_cmp++;
        if (wr_seen != 0) begin
            n_err++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", wr_seen);
        end
        run_walk(va, 8'h22, 32'h0, 64'h0010_0000_0000_0777, 1);
        n_cmp++;
        if (obs_tlbadr[11:10] !== 2'd0) begin
            n_err++; $display("FAIL rstmid_way: got %0d want 0", obs_tlbadr[11:10]);
        end
        way_model = 1;
    endtask

    task automatic test_random();
        logic [31:0] va, ptbr;
        logic [7:0]  asid;
        logic [63:0] pte;
        int ack_at, bad;
        for (int i = 0; i < 24; i++) begin
            va = $urandom; ptbr = $urandom & 32'hFFFF_FFF8; asid = 8'($urandom_range(0, 255));
            pte = {$urandom, $urandom};
            pte[52] = ($urandom_range(0, 3) != 0);
            ack_at = $urandom_range(1, 6);
            run_walk(va, asid, ptbr, pte, ack_at);
            bad = 0;
            if (obs_adr !== model_adr(ptbr, va)) bad |= 1;
            if (pte[52]) begin
                if (obs_writes != 1 || obs_tlbadr !== model_tlbadr(way_model, va)) bad |= 2;
                if (obs_tlbdat !== model_entry(va, asid, pte)) bad |= 4;
                if (obs_wr_c != ack_at + 1 || obs_done_c != ack_at + 2) bad |= 8;
                way_model = (way_model + 1) % 4;
            end else begin
                if (obs_writes != 0 || obs_code !== 2'd1 || obs_fault_c != ack_at + 1) bad |= 16;
            end
            n_cmp++;
            if (bad != 0) begin
                n_err++; $display("FAIL rand%0d: va %h pte %h got adr %h tlb %h/%h code %0d want adr %h tlb %h/%h (flags %0d)",
                                  i, va, pte, obs_adr, obs_tlbadr, obs_tlbdat, obs_code, model_adr(ptbr, va),
                                  model_tlbadr(way_model, va), model_entry(va, asid, pte), bad);
            end
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0, last_done = -1, gap = -1, nwr = 0;
        logic prev_cyc = 1'b0;
        logic [1:0] ways [2];
        apply_reset();
        ways[0] = 2'd3; ways[1] = 2'd3;
        miss_adr_i = 32'h0ABC_D000; asid_i = 8'h3C; ptbr_i = 32'h0200_0000;
        dat_i = 64'h0010_0000_0000_1234; miss_i = 1'b1;
        for (int c = 0; c < 60 && dones < 2; c++) begin
            tick();
            ack_i = cyc_o;
            if (wrtlb_o && nwr < 2) begin ways[nwr] = tlbadr_o[11:10]; nwr++; end
            if (cyc_o && !prev_cyc && last_done >= 0 && gap < 0) gap = c - last_done;
            if (done_o) begin dones++; last_done = c; end
            prev_cyc = cyc_o;
        end
        miss_i = 1'b0; ack_i = 1'b0;
        n_cmp++;
        if (dones != 2 || gap != 2) begin
            n_err++; $display("FAIL b2b_rearm: got %0d dones gap %0d want 2/2", dones, gap);
        end
        n_cmp++;
        if (nwr != 2 || ways[0] !== 2'd0 || ways[1] !== 2'd1) begin
            n_err++; $display("FAIL b2b_ways: got %0d writes ways %0d,%0d want 2 / 0,1", nwr, ways[0], ways[1]);
        end
        tick();
        way_model = 2;
    endtask

`ifdef ANY1_TLBW_INVAL_EN
    task automatic test_inval();
        int idx = 0, bad = 0, cyc_during = 0, busy_bad = 0, served = 0;
        bit fin = 0;
        logic [11:0] wr_adr = 12'hFFF;
        logic [31:0] va = 32'h1234_5678;
        inv_i = 1'b1;
        tick();
        inv_i = 1'b0;
        miss_adr_i = va; asid_i = 8'h05; ptbr_i = 32'h0010_0000; dat_i = 64'h001F_0000_0000_0ABC;
        for (int c = 0; c < 5000 && !fin; c++) begin
            if (c == 100) miss_i = 1'b1;
            if (cyc_o) cyc_during++;
            if (!busy_o && !done_o) busy_bad++;
            if (wrtlb_o) begin
                if (tlbadr_o !== 12'(idx) || tlbdat_o !== 64'h0 || tlben_o !== 1'b1) bad++;
                idx++;
            end
            if (done_o) fin = 1;
            else tick();
        end
        n_cmp++;
        if (!fin || idx != 4096 || bad != 0) begin
            n_err++; $display("FAIL inval_sweep: got done %0d writes %0d bad %0d want 1/4096/0", fin, idx, bad);
        end
        n_cmp++;
        if (cyc_during != 0 || busy_bad != 0) begin
            n_err++; $display("FAIL inval_isolation: got bus cycles %0d busy gaps %0d want 0/0", cyc_during, busy_bad);
        end
        for (int c = 0; c < 20 && served == 0; c++) begin
            tick();
            ack_i = cyc_o;
            if (cyc_o) miss_i = 1'b0;
            if (wrtlb_o) wr_adr = tlbadr_o;
            if (done_o) served = 1;
        end
        miss_i = 1'b0; ack_i = 1'b0;
        n_cmp++;
        if (served != 1 || wr_adr !== model_tlbadr(0, va)) begin
            n_err++; $display("FAIL inval_then_miss: got served %0d adr %h want 1/%h", served, wr_adr, model_tlbadr(0, va));
        end
        tick();
        way_model = 1;
    endtask
`else
    task automatic test_inv_ignored();
        int active = 0;
        inv_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy_o || wrtlb_o || tlben_o || done_o) active++;
        end
        inv_i = 1'b0;
        n_cmp++;
        if (active != 0) begin
            n_err++; $display("FAIL inv_ignored: got %0d active cycles want 0", active);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_round_robin();
        test_invalid_pte();
        test_timeout();
        test_reset_midwalk();
        test_random();
        test_back_to_back();
`ifdef ANY1_TLBW_INVAL_EN
        test_inval();
`else
        test_inv_ignored();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
